// File: rtl/zap_cp_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : zap_cp_dispatch_pkg
// Brief   : Shared state encodings, opcode-class constants and the
//           instruction classifier for the coprocessor dispatcher.
// Revision: 1.0 - initial release
// ============================================================================
package zap_cp_dispatch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRAIN = 3'd1,
    ST_ISSUE = 3'd2,
    ST_COOL  = 3'd3,
    ST_TRAP  = 3'd4
  } cp_state_t;

  typedef enum logic [1:0] {
    CLS_NONE        = 2'd0,
    CLS_DISPATCH    = 2'd1,
    CLS_UNSUPPORTED = 2'd2
  } cp_class_t;

  localparam logic [3:0] C_CP_CLASS    = 4'b1110;
  localparam logic [2:0] C_LDC_STC     = 3'b110;
  localparam int         C_COOL_CYCLES = 2;

  // Only bits [27:24] and [4] matter for classification, so only those are
  // passed in. [27:24]==1110 and [27:25]==110 are disjoint encodings.
  function automatic cp_class_t classify(input logic       valid,
                                         input logic [3:0] op_hi,
                                         input logic       bit4);
    cp_class_t cls;
    cls = CLS_NONE;
    if (valid) begin
      if (op_hi == C_CP_CLASS) begin
        cls = bit4 ? CLS_DISPATCH : CLS_UNSUPPORTED;
      end else if (op_hi[3:1] == C_LDC_STC) begin
        cls = CLS_UNSUPPORTED;
      end
    end
    return cls;
  endfunction

endpackage
`default_nettype wire

// File: rtl/zap_cp_timeout.sv
`default_nettype none
// ============================================================================
// Module  : zap_cp_timeout
// Brief   : Saturating cycle counter with synchronous clear, count enable and
//           a terminal-count flag at TIMEOUT-1.
// Revision: 1.0 - initial release
// ============================================================================
module zap_cp_timeout #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output logic             o_tc
);

  localparam logic [CNT_W-1:0] C_SAT  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] C_TERM = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;

  // Count up while enabled; hold at TIMEOUT so the value never wraps.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != C_SAT)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == C_TERM);

endmodule
`default_nettype wire

// File: rtl/zap_cp_dispatch.sv
`default_nettype none
// ============================================================================
// Module  : zap_cp_dispatch
// Brief   : Issue-stage coprocessor dispatcher. Holds MRC/MCR until the
//           pipeline drains, presents word + CPSR snapshot with dav until the
//           coprocessor completes, and traps on timeout or unsupported class.
//           TIMEOUT must be at least 8.
// Revision: 1.0 - initial release
// ============================================================================
module zap_cp_dispatch
  import zap_cp_dispatch_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_instr,
  input  logic        i_instr_valid,
  input  logic [31:0] i_cpsr,
  input  logic        i_pipe_empty,
  input  logic        i_cp_done,
  output logic [31:0] o_cp_word,
  output logic        o_cp_dav,
  output logic [31:0] o_cpsr,
  output logic        o_stall,
  output logic        o_und,
  output logic [31:0] o_und_instr
);

  localparam logic [CNT_W-1:0] C_COOL_LAST = CNT_W'(C_COOL_CYCLES - 1);

  cp_state_t        r_state;
  cp_state_t        w_state_next;
  cp_class_t        w_class;
  logic             w_cnt_clr;
  logic             w_cnt_en;
  logic [CNT_W-1:0] w_cnt;
  logic             w_cnt_tc;

  logic [31:0]      r_cp_word;
  logic             r_cp_dav;
  logic [31:0]      r_cpsr;
  logic             r_und;
  logic [31:0]      r_und_instr;

  assign w_class = classify(i_instr_valid, i_instr[27:24], i_instr[4]);

  // One counter serves both the ISSUE timeout and the COOL length; it is
  // cleared on every state change so each phase starts counting from zero.
  zap_cp_timeout #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .o_count (w_cnt),
    .o_tc    (w_cnt_tc)
  );

  // Next-state decode and counter control.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_class == CLS_DISPATCH) begin
          w_state_next = ST_DRAIN;
        end else if (w_class == CLS_UNSUPPORTED) begin
          w_state_next = ST_TRAP;
        end
      end
      ST_DRAIN: begin
        if (i_pipe_empty) begin
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // done takes priority over the terminal count
        if (i_cp_done) begin
          w_state_next = ST_COOL;
        end else if (w_cnt_tc) begin
          w_state_next = ST_TRAP;
        end
      end
      ST_COOL: begin
        if (w_cnt == C_COOL_LAST) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_TRAP: begin
        w_state_next = ST_COOL;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    w_cnt_clr = (w_state_next != r_state);
    w_cnt_en  = (r_state == ST_ISSUE) || (r_state == ST_COOL);
  end

  // State register, operand capture and trap reporting.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_cp_word   <= '0;
      r_cp_dav    <= 1'b0;
      r_cpsr      <= '0;
      r_und       <= 1'b0;
      r_und_instr <= '0;
    end else begin
      r_state <= w_state_next;
      r_und   <= (w_state_next == ST_TRAP);
      case (r_state)
        ST_IDLE: begin
          if (w_class == CLS_DISPATCH) begin
            r_cp_word <= i_instr;
            r_cpsr    <= i_cpsr;
          end else if (w_class == CLS_UNSUPPORTED) begin
            r_und_instr <= i_instr;
          end
        end
        ST_DRAIN: begin
          if (i_pipe_empty) begin
            r_cp_dav <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (i_cp_done) begin
            r_cp_dav <= 1'b0;
          end else if (w_cnt_tc) begin
            r_cp_dav    <= 1'b0;
            r_und_instr <= r_cp_word;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_stall     = (r_state != ST_IDLE) || (w_class != CLS_NONE);
  assign o_cp_word   = r_cp_word;
  assign o_cp_dav    = r_cp_dav;
  assign o_cpsr      = r_cpsr;
  assign o_und       = r_und;
  assign o_und_instr = r_und_instr;

endmodule
`default_nettype wire

// File: tb/tb_zap_cp_dispatch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_zap_cp_dispatch
// Brief   : Self-checking bench for zap_cp_dispatch. Each transaction is
//           described by a few timing parameters; expected outputs per cycle
//           are derived from the resulting timeline.
// Revision: 1.0 - initial release
// ============================================================================
module tb_zap_cp_dispatch;

  localparam int TIMEOUT = 64;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_instr;
  logic        i_instr_valid;
  logic [31:0] i_cpsr;
  logic        i_pipe_empty;
  logic        i_cp_done;
  logic [31:0] o_cp_word;
  logic        o_cp_dav;
  logic [31:0] o_cpsr;
  logic        o_stall;
  logic        o_und;
  logic [31:0] o_und_instr;

  int n_pass  = 0;
  int n_total = 0;

  // Transaction descriptor. Cycle 0 is the cycle the instruction is offered.
  int          t_kind;     // 0 ignored, 1 dispatch, 2 unsupported
  logic [31:0] t_instr;
  logic [31:0] t_cpsr;
  logic        t_valid0;
  int          t_drain;    // cycles pipe_empty stays low once in DRAIN
  int          t_done_k;   // done offered this many cycles after dav rises, -1 never
  int          t_dup_at;   // extra done pulse at this cycle, -1 none
  bit          t_noise;

  always #5 i_clk = ~i_clk;

  zap_cp_dispatch #(.TIMEOUT(TIMEOUT)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_instr       (i_instr),
    .i_instr_valid (i_instr_valid),
    .i_cpsr        (i_cpsr),
    .i_pipe_empty  (i_pipe_empty),
    .i_cp_done     (i_cp_done),
    .o_cp_word     (o_cp_word),
    .o_cp_dav      (o_cp_dav),
    .o_cpsr        (o_cpsr),
    .o_stall       (o_stall),
    .o_und         (o_und),
    .o_und_instr   (o_und_instr)
  );

  // ---------------- timeline model ----------------
  function automatic bit done_in_time();
    return (t_done_k >= 0) && (t_done_k < TIMEOUT);
  endfunction

  function automatic int dav_rise();
    return t_drain + 2;
  endfunction

  function automatic int dav_fall();
    return dav_rise() + (done_in_time() ? t_done_k + 1 : TIMEOUT);
  endfunction

  function automatic int cool_start();
    if (t_kind == 2) return 2;
    return dav_fall() + (done_in_time() ? 0 : 1);
  endfunction

  // Includes one trailing idle cycle.
  function automatic int txn_len();
    if (t_kind == 0) return 1;
    return cool_start() + 3;
  endfunction

  task automatic exp_at(input int t, output logic e_stall, output logic e_dav,
                        output logic e_und);
    e_stall = (t_kind != 0) && (t < cool_start() + 2);
    e_dav   = (t_kind == 1) && (t >= dav_rise()) && (t < dav_fall());
    e_und   = ((t_kind == 2) && (t == 1)) ||
              ((t_kind == 1) && !done_in_time() && (t == dav_fall()));
  endtask

  task automatic drive_at(input int t);
    i_instr_valid = 1'b0;
    i_cp_done     = 1'b0;
    if (t_noise) begin
      i_instr      = $urandom;
      i_cpsr       = $urandom;
      i_pipe_empty = 1'($urandom);
    end else begin
      i_instr      = 32'h0;
      i_cpsr       = 32'h0;
      i_pipe_empty = 1'b1;
    end
    if (t == 0) begin
      i_instr_valid = t_valid0;
      i_instr       = t_instr;
      i_cpsr        = t_cpsr;
      if (t_noise) i_cp_done = 1'($urandom);
    end else if (t < txn_len() - 1) begin
      if (t_noise) i_instr_valid = 1'($urandom);
      if (t_kind == 1) begin
        if (t <= t_drain) i_pipe_empty = 1'b0;
        else if (t == t_drain + 1) i_pipe_empty = 1'b1;
        if (t >= dav_rise() && t < dav_fall())
          i_cp_done = (t == dav_rise() + t_done_k);
        else if (t >= dav_fall() && t_noise)
          i_cp_done = 1'($urandom);
      end else if (t_noise) begin
        i_cp_done = 1'($urandom);
      end
    end
    if (t == t_dup_at) i_cp_done = 1'b1;
  endtask

  task automatic idle_inputs();
    i_instr = 32'h0; i_instr_valid = 1'b0; i_cpsr = 32'h0;
    i_pipe_empty = 1'b1; i_cp_done = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_reset = 1'b1;
    idle_inputs();
    repeat (3) @(posedge i_clk);
    #1 i_reset = 1'b0;
    @(negedge i_clk);
    n_total++; if (o_cp_dav !== 1'b0) $display("FAIL reset_dav got %0b want 0", o_cp_dav); else n_pass++;
    n_total++; if (o_stall !== 1'b0) $display("FAIL reset_stall got %0b want 0", o_stall); else n_pass++;
    n_total++; if (o_und !== 1'b0) $display("FAIL reset_und got %0b want 0", o_und); else n_pass++;
    n_total++; if (o_cp_word !== 32'h0) $display("FAIL reset_cp_word got %h want 0", o_cp_word); else n_pass++;
    n_total++; if (o_cpsr !== 32'h0) $display("FAIL reset_cpsr got %h want 0", o_cpsr); else n_pass++;
    n_total++; if (o_und_instr !== 32'h0) $display("FAIL reset_und_instr got %h want 0", o_und_instr); else n_pass++;
    @(posedge i_clk); #1;
  endtask

  task automatic test_directed();
    logic e_stall, e_dav, e_und;
    for (int s = 0; s < 9; s++) begin
      t_kind = 1; t_valid0 = 1'b1; t_drain = 0; t_done_k = 1; t_dup_at = -1;
      t_noise = 1'b0; t_cpsr = 32'h0000_0010; t_instr = 32'hEE01_0F10;
      case (s)
        1: begin t_drain = 5; t_done_k = 0; end           // drain wait
        2: begin t_instr = 32'hEE11_0F10; t_done_k = -1; end // timeout
        3: begin t_kind = 2; t_instr = 32'hEE00_0F00; end  // CDP
        4: t_dup_at = 5;                                   // duplicate done in COOL
        5: begin t_kind = 2; t_instr = 32'hEC10_0000; end  // LDC/STC
        6: t_done_k = TIMEOUT - 1;                         // done on terminal count
        7: begin t_kind = 0; t_instr = 32'hE1A0_0000; end  // ordinary instruction
        8: begin t_kind = 0; t_valid0 = 1'b0; end          // MCR word, not valid
        default: ;
      endcase
      for (int t = 0; t < txn_len(); t++) begin
        drive_at(t);
        @(negedge i_clk);
        exp_at(t, e_stall, e_dav, e_und);
        n_total++;
        if (o_stall !== e_stall) $display("FAIL dir%0d stall t=%0d got %0b want %0b", s, t, o_stall, e_stall); else n_pass++;
        n_total++;
        if (o_cp_dav !== e_dav) $display("FAIL dir%0d dav t=%0d got %0b want %0b", s, t, o_cp_dav, e_dav); else n_pass++;
        n_total++;
        if (o_und !== e_und) $display("FAIL dir%0d und t=%0d got %0b want %0b", s, t, o_und, e_und); else n_pass++;
        if (t_kind == 1 && t >= 1) begin
          n_total++;
          if (o_cp_word !== t_instr) $display("FAIL dir%0d cp_word t=%0d got %h want %h", s, t, o_cp_word, t_instr); else n_pass++;
          n_total++;
          if (o_cpsr !== t_cpsr) $display("FAIL dir%0d cpsr t=%0d got %h want %h", s, t, o_cpsr, t_cpsr); else n_pass++;
        end
        if (e_und) begin
          n_total++;
          if (o_und_instr !== t_instr) $display("FAIL dir%0d und_instr t=%0d got %h want %h", s, t, o_und_instr, t_instr); else n_pass++;
        end
        @(posedge i_clk); #1;
      end
    end
  endtask

  task automatic test_reset_in_issue();
    idle_inputs();
    i_instr_valid = 1'b1; i_instr = 32'hEE01_0F10; i_cpsr = 32'h0000_001F;
    @(posedge i_clk); #1 idle_inputs();
    @(posedge i_clk); #1;
    @(negedge i_clk);
    n_total++; if (o_cp_dav !== 1'b1) $display("FAIL rst_issue_pre_dav got %0b want 1", o_cp_dav); else n_pass++;
    @(posedge i_clk); #1 i_reset = 1'b1;
    @(posedge i_clk); #1 i_reset = 1'b0;
    @(negedge i_clk);
    n_total++; if (o_cp_dav !== 1'b0) $display("FAIL rst_issue_dav got %0b want 0", o_cp_dav); else n_pass++;
    n_total++; if (o_stall !== 1'b0) $display("FAIL rst_issue_stall got %0b want 0", o_stall); else n_pass++;
    n_total++; if (o_cp_word !== 32'h0) $display("FAIL rst_issue_cp_word got %h want 0", o_cp_word); else n_pass++;
    n_total++; if (o_cpsr !== 32'h0) $display("FAIL rst_issue_cpsr got %h want 0", o_cpsr); else n_pass++;
    // A fresh MCR dispatches normally afterwards.
    @(posedge i_clk); #1;
    i_instr_valid = 1'b1; i_instr = 32'hEE01_0F10; i_cpsr = 32'h0000_0010;
    @(negedge i_clk);
    n_total++; if (o_stall !== 1'b1) $display("FAIL post_rst_stall0 got %0b want 1", o_stall); else n_pass++;
    @(posedge i_clk); #1 idle_inputs();
    @(negedge i_clk);
    n_total++; if (o_cp_dav !== 1'b0) $display("FAIL post_rst_dav1 got %0b want 0", o_cp_dav); else n_pass++;
    @(posedge i_clk); #1 i_cp_done = 1'b1;
    @(negedge i_clk);
    n_total++; if (o_cp_dav !== 1'b1) $display("FAIL post_rst_dav2 got %0b want 1", o_cp_dav); else n_pass++;
    n_total++; if (o_cp_word !== 32'hEE01_0F10) $display("FAIL post_rst_word got %h want ee010f10", o_cp_word); else n_pass++;
    n_total++; if (o_cpsr !== 32'h0000_0010) $display("FAIL post_rst_cpsr got %h want 00000010", o_cpsr); else n_pass++;
    @(posedge i_clk); #1 i_cp_done = 1'b0;
    @(negedge i_clk);
    n_total++; if (o_cp_dav !== 1'b0) $display("FAIL post_rst_dav3 got %0b want 0", o_cp_dav); else n_pass++;
    n_total++; if (o_stall !== 1'b1) $display("FAIL post_rst_stall3 got %0b want 1", o_stall); else n_pass++;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    @(negedge i_clk);
    n_total++; if (o_stall !== 1'b0) $display("FAIL post_rst_stall5 got %0b want 0", o_stall); else n_pass++;
    @(posedge i_clk); #1;
  endtask

  task automatic test_random();
    logic e_stall, e_dav, e_und;
    int   sel;
    for (int n = 0; n < 40; n++) begin
      t_noise = 1'b1; t_valid0 = 1'b1; t_dup_at = -1;
      t_cpsr  = $urandom;
      t_drain = int'($urandom_range(0, 6));
      sel     = int'($urandom_range(0, 9));
      t_done_k = (sel == 0) ? -1 : (sel == 1) ? TIMEOUT - 1 : int'($urandom_range(0, 10));
      sel = int'($urandom_range(0, 4));
      case (sel)
        0: begin t_kind = 1; t_instr = ($urandom & ~32'h0F00_0010) | 32'h0E00_0010; end
        1: begin t_kind = 2; t_instr = ($urandom & ~32'h0F00_0010) | 32'h0E00_0000; end
        2: begin t_kind = 2; t_instr = ($urandom & ~32'h0E00_0000) | 32'h0C00_0000; end
        3: begin
          t_kind = 0;
          do t_instr = $urandom;
          while (t_instr[27:24] == 4'hE || t_instr[27:25] == 3'b110);
        end
        default: begin
          t_kind = 0; t_valid0 = 1'b0;
          t_instr = ($urandom & ~32'h0F00_0000) | 32'h0E00_0000;
        end
      endcase
      for (int t = 0; t < txn_len(); t++) begin
        drive_at(t);
        @(negedge i_clk);
        exp_at(t, e_stall, e_dav, e_und);
        n_total++;
        if (o_stall !== e_stall) $display("FAIL rnd%0d stall t=%0d got %0b want %0b", n, t, o_stall, e_stall); else n_pass++;
        n_total++;
        if (o_cp_dav !== e_dav) $display("FAIL rnd%0d dav t=%0d got %0b want %0b", n, t, o_cp_dav, e_dav); else n_pass++;
        n_total++;
        if (o_und !== e_und) $display("FAIL rnd%0d und t=%0d got %0b want %0b", n, t, o_und, e_und); else n_pass++;
        if (t_kind == 1 && t >= 1) begin
          n_total++;
          if (o_cp_word !== t_instr) $display("FAIL rnd%0d cp_word t=%0d got %h want %h", n, t, o_cp_word, t_instr); else n_pass++;
          n_total++;
          if (o_cpsr !== t_cpsr) $display("FAIL rnd%0d cpsr t=%0d got %h want %h", n, t, o_cpsr, t_cpsr); else n_pass++;
        end
        if (e_und) begin
          n_total++;
          if (o_und_instr !== t_instr) $display("FAIL rnd%0d und_instr t=%0d got %h want %h", n, t, o_und_instr, t_instr); else n_pass++;
        end
        @(posedge i_clk); #1;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_reset_in_issue();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
